// File: rtl/fsm_stim_player_if.sv
// Bus bundle for fsm_stim_player: vector loading, playback control, and the
// stimulus/response pins of the FSM under control.
interface fsm_stim_player_if #(
  parameter int IN_LEN  = 8,
  parameter int DEPTH   = 131,
  parameter int OUT_LEN = 19
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               ld_en;
  logic [IN_LEN:0]    ld_data;
  logic               clr;
  logic               start;
  logic               abort;
  logic [OUT_LEN-1:0] dut_out;
  logic               dut_rst;
  logic [IN_LEN-1:0]  dut_in;
  logic [CNT_W-1:0]   vec_cnt;
  logic               full;
  logic               busy;
  logic               done;
  logic [OUT_LEN-1:0] sig;

  modport master (
    output ld_en, ld_data, clr, start, abort, dut_out,
    input  dut_rst, dut_in, vec_cnt, full, busy, done, sig
  );

  modport slave (
    input  ld_en, ld_data, clr, start, abort, dut_out,
    output dut_rst, dut_in, vec_cnt, full, busy, done, sig
  );
endinterface

// File: rtl/fsm_stim_player.sv
// Stores {fsm_rst, fsm_in} vectors and replays them one per cycle into an FSM.
// Define FSM_STIM_SIG_EN to build the rotate-XOR output signature on sig.
module fsm_stim_player #(
  parameter int IN_LEN  = 8,
  parameter int DEPTH   = 131,
  parameter int OUT_LEN = 19
) (
  input logic               clk,
  input logic               rst,
  fsm_stim_player_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              dut_rst_q, dut_rst_d;
  logic [IN_LEN-1:0] dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en;
  logic              full_w;
  logic [IN_LEN:0]   rd_vec;

  logic [IN_LEN:0]   mem [DEPTH];

  assign full_w = (vec_cnt_q == CNT_W'(DEPTH));
  assign rd_vec = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    dut_rst_d = 1'b1;
    dut_in_d  = '0;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start outranks clr, and clr outranks ld_en
        if (bus.start) begin
          rd_ptr_d = '0;
          state_d  = (vec_cnt_q != '0) ? S_PLAY : S_DONE;
        end else if (bus.clr) begin
          vec_cnt_d = '0;
        end else if (bus.ld_en && !full_w) begin
          wr_en     = 1'b1;
          vec_cnt_d = vec_cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          rd_ptr_d = '0;
        end else begin
          {dut_rst_d, dut_in_d} = rd_vec;
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == vec_cnt_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d  = bus.abort ? S_IDLE : S_DONE;
        rd_ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_PLAY) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_cnt_q <= '0;
      rd_ptr_q  <= '0;
      dut_rst_q <= 1'b1;
      dut_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      dut_rst_q <= dut_rst_d;
      dut_in_q  <= dut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Vector store has no reset; its contents are only meaningful below vec_cnt.
  always_ff @(posedge clk) begin
    if (wr_en) mem[vec_cnt_q[AW-1:0]] <= bus.ld_data;
  end

`ifdef FSM_STIM_SIG_EN
  logic [OUT_LEN-1:0] sig_q, sig_d;

  function automatic logic [OUT_LEN-1:0] rotl1(input logic [OUT_LEN-1:0] v);
    return {v[OUT_LEN-2:0], v[OUT_LEN-1]};
  endfunction

  // The first PLAY edge is skipped so each playback captures exactly vec_cnt samples.
  always_comb begin
    sig_d = sig_q;
    if (state_q == S_IDLE && bus.start && vec_cnt_q != '0)
      sig_d = '0;
    else if (!bus.abort && ((state_q == S_PLAY && rd_ptr_q != '0) || state_q == S_DRAIN))
      sig_d = rotl1(sig_q) ^ bus.dut_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

  assign bus.dut_rst = dut_rst_q;
  assign bus.dut_in  = dut_in_q;
  assign bus.vec_cnt = vec_cnt_q;
  assign bus.full    = full_w;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
